// File: rtl/traffic_display_if.sv
// Controller-to-display bundle: light codes and countdowns in, segment/digit/lamp drive out.
interface traffic_display_if;
  logic [2:0] south_north_light;
  logic [2:0] east_west_light;
  logic [3:0] south_north_count;
  logic [3:0] east_west_count;
  logic [7:0] seg;
  logic [3:0] dig_sel;
  logic [2:0] sn_led;
  logic [2:0] ew_led;

  modport master (
    output south_north_light, east_west_light, south_north_count, east_west_count,
    input  seg, dig_sel, sn_led, ew_led
  );

  modport slave (
    input  south_north_light, east_west_light, south_north_count, east_west_count,
    output seg, dig_sel, sn_led, ew_led
  );
endinterface

// File: rtl/traffic_display.sv
// Traffic display stage: 4-digit multiplexed 7-segment scan plus blinking lamp drive.
// Direction 0 is east-west, direction 1 is south-north throughout.

module traffic_display_dir (
  input  logic [2:0] light,
  input  logic [3:0] count,
  input  logic       all_red,
  input  logic       blink,
  output logic [6:0] light_gl,
  output logic [6:0] count_gl,
  output logic [2:0] led
);
  always_comb begin
    case (light)
      3'b001:  light_gl = 7'h3D;
      3'b010:  light_gl = 7'h6E;
      3'b100:  light_gl = 7'h50;
      default: light_gl = 7'h79;
    endcase
  end

  // All-red overrides the numeric countdown with a dash on both directions.
  always_comb begin
    if (all_red) count_gl = 7'h40;
    else begin
      case (count)
        4'd0:    count_gl = 7'h3F;
        4'd1:    count_gl = 7'h06;
        4'd2:    count_gl = 7'h5B;
        4'd3:    count_gl = 7'h4F;
        4'd4:    count_gl = 7'h66;
        4'd5:    count_gl = 7'h6D;
        4'd6:    count_gl = 7'h7D;
        4'd7:    count_gl = 7'h07;
        4'd8:    count_gl = 7'h7F;
        4'd9:    count_gl = 7'h6F;
        default: count_gl = 7'h79;
      endcase
    end
  end

  // Lamp order is {red,yellow,green}.
  always_comb begin
    if (all_red) led = {blink, 2'b00};
    else begin
      case (light)
        3'b001:  led = 3'b001;
        3'b010:  led = {1'b0, blink, 1'b0};
        3'b100:  led = 3'b100;
        default: led = 3'b000;
      endcase
    end
  end
endmodule

module traffic_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  logic             clk,
  input  logic             rst_n,
  traffic_display_if.slave td
);
  localparam int NUM_DIR = 2;
  localparam int CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [NUM_DIR-1:0][2:0] light_s;
  logic [NUM_DIR-1:0][3:0] count_s;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [FRM_W-1:0] frm;
  logic             blink;

  logic [NUM_DIR-1:0][6:0] light_gl;
  logic [NUM_DIR-1:0][6:0] count_gl;
  logic [NUM_DIR-1:0][2:0] led;
  logic                    all_red;

  logic [7:0] seg_d, seg_q;
  logic [3:0] dig_d, dig_q;
  logic [2:0] sn_led_q, ew_led_q;

  logic cnt_wrap, frm_wrap, frm_term, blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      light_s <= '0;
      count_s <= '0;
    end else begin
      light_s <= {td.south_north_light, td.east_west_light};
      count_s <= {td.south_north_count, td.east_west_count};
    end
  end

  assign cnt_wrap = (cnt == CNT_W'(SCAN_DIV - 1));
  assign frm_wrap = cnt_wrap && (idx == 2'd3);
  assign frm_term = frm_wrap && (frm == FRM_W'(BLINK_FRAMES - 1));

  // Slot, frame and blink timebase; a terminal frame clears and toggles on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      frm   <= '0;
      blink <= 1'b0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap) idx <= idx + 2'd1;
      if (frm_term) begin
        frm   <= '0;
        blink <= ~blink;
      end else if (frm_wrap) begin
        frm <= frm + 1'b1;
      end
    end
  end

  assign all_red = (light_s[0] == 3'b100) && (light_s[1] == 3'b100);

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_dir
    traffic_display_dir u_dir (
      .light    (light_s[d]),
      .count    (count_s[d]),
      .all_red  (all_red),
      .blink    (blink),
      .light_gl (light_gl[d]),
      .count_gl (count_gl[d]),
      .led      (led[d])
    );
  end

  // idx[1] selects the direction, idx[0] selects count (0) or light glyph (1).
  assign blank = (cnt < CNT_W'(BLANK_CYC));

  always_comb begin
    seg_d = 8'hFF;
    dig_d = 4'hF;
    if (!blank) begin
      seg_d = ~{1'b0, (idx[0] ? light_gl[idx[1]] : count_gl[idx[1]])};
      dig_d = ~(4'b0001 << idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= 8'hFF;
      dig_q    <= 4'hF;
      sn_led_q <= 3'b000;
      ew_led_q <= 3'b000;
    end else begin
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      sn_led_q <= led[1];
      ew_led_q <= led[0];
    end
  end

  assign td.seg     = seg_q;
  assign td.dig_sel = dig_q;
  assign td.sn_led  = sn_led_q;
  assign td.ew_led  = ew_led_q;
endmodule

// File: tb/tb_traffic_display.sv
// Bench for traffic_display: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a timeline-based model.
module tb_traffic_display;
  localparam int S = 8;
  localparam int B = 2;
  localparam int F = 2;

  logic clk = 1'b0;
  logic rst_n;
  traffic_display_if tif ();

  traffic_display #(.SCAN_DIV(S), .BLANK_CYC(B), .BLINK_FRAMES(F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .td    (tif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n = 0;              // rising edges since reset release
  logic [13:0] smp = '0;  // inputs captured at the previous edge {snl,ewl,snc,ewc}

  localparam logic [6:0] DIGS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", nm, act, exp, n, $time);
    end
  endtask

  function automatic logic [6:0] light_glyph(input logic [2:0] l);
    if (l == 3'b001) return 7'h3D;
    if (l == 3'b010) return 7'h6E;
    if (l == 3'b100) return 7'h50;
    return 7'h79;
  endfunction

  function automatic logic [6:0] count_glyph(input logic [3:0] c, input bit ar);
    if (ar) return 7'h40;
    if (c > 4'd9) return 7'h79;
    return DIGS[c];
  endfunction

  function automatic logic [2:0] lamp(input logic [2:0] l, input bit ar, input bit bl);
    if (ar) return {bl, 2'b00};
    if (l == 3'b001) return 3'b001;
    if (l == 3'b010) return {1'b0, bl, 1'b0};
    if (l == 3'b100) return 3'b100;
    return 3'b000;
  endfunction

  // m = cycles elapsed since release at the time the outputs are computed.
  task automatic model(input int m, input logic [13:0] s, output logic [7:0] eseg,
                       output logic [3:0] edig, output logic [2:0] esn, output logic [2:0] eew);
    logic [2:0] snl, ewl;
    logic [3:0] snc, ewc;
    logic [6:0] g;
    int c, ix;
    bit bl, ar;
    {snl, ewl, snc, ewc} = s;
    c  = m % S;
    ix = (m / S) % 4;
    bl = ((m / (4 * S * F)) % 2) == 1;
    ar = (snl == 3'b100) && (ewl == 3'b100);
    case (ix)
      0:       g = count_glyph(ewc, ar);
      1:       g = light_glyph(ewl);
      2:       g = count_glyph(snc, ar);
      default: g = light_glyph(snl);
    endcase
    if (c < B) begin
      eseg = 8'hFF;
      edig = 4'hF;
    end else begin
      eseg = ~{1'b0, g};
      edig = 4'hF;
      edig[ix] = 1'b0;
    end
    esn = lamp(snl, ar, bl);
    eew = lamp(ewl, ar, bl);
  endtask

  always begin
    logic [7:0] eseg;
    logic [3:0] edig;
    logic [2:0] esn, eew;
    logic [13:0] cur;
    @(posedge clk);
    cur = {tif.south_north_light, tif.east_west_light, tif.south_north_count, tif.east_west_count};
    if (!rst_n) begin
      n = 0;
      smp = '0;
      eseg = 8'hFF; edig = 4'hF; esn = 3'b000; eew = 3'b000;
    end else begin
      n++;
      model(n - 1, smp, eseg, edig, esn, eew);
      smp = cur;
    end
    #1;
    chk("seg", tif.seg, eseg);
    chk("dig_sel", {4'h0, tif.dig_sel}, {4'h0, edig});
    chk("sn_led", {5'h0, tif.sn_led}, {5'h0, esn});
    chk("ew_led", {5'h0, tif.ew_led}, {5'h0, eew});
  end

  task automatic set_in(input logic [2:0] snl, input logic [3:0] snc,
                        input logic [2:0] ewl, input logic [3:0] ewc);
    tif.south_north_light = snl;
    tif.south_north_count = snc;
    tif.east_west_light   = ewl;
    tif.east_west_count   = ewc;
  endtask

  task automatic restart(input logic [2:0] snl, input logic [3:0] snc,
                         input logic [2:0] ewl, input logic [3:0] ewc);
    @(negedge clk);
    rst_n = 1'b0;
    set_in(snl, snc, ewl, ewc);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance to just after rising edge k since release.
  task automatic goto(input int k);
    if (k <= n) begin
      checks++; failures++;
      $display("FAIL goto: edge %0d already passed (at %0d)", k, n);
    end
    repeat (k - n) @(posedge clk);
    #2;
  endtask

  function automatic logic [2:0] rnd_light();
    int r = $urandom_range(0, 9);
    if (r < 3) return 3'b001;
    if (r < 6) return 3'b010;
    if (r < 8) return 3'b100;
    if (r == 8) return 3'($urandom_range(0, 7));
    return 3'b100;
  endfunction

  initial begin
    rst_n = 1'b1;
    set_in(3'b000, 4'd0, 3'b000, 4'd0);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", tif.seg, 8'hFF);
    chk("rst_dig", {4'h0, tif.dig_sel}, 8'h0F);

    // Scan order and glyphs
    restart(3'b001, 4'd9, 3'b100, 4'd4);
    goto(2);  chk("s1_dig_blank", {4'h0, tif.dig_sel}, 8'h0F);
              chk("s1_sn_led", {5'h0, tif.sn_led}, 8'h01);
              chk("s1_ew_led", {5'h0, tif.ew_led}, 8'h04);
    goto(3);  chk("s1_dig0", {4'h0, tif.dig_sel}, 8'h0E); chk("s1_seg0", tif.seg, 8'h99);
    goto(8);  chk("s1_dig0_end", {4'h0, tif.dig_sel}, 8'h0E);
    goto(9);  chk("s1_blank1", {4'h0, tif.dig_sel}, 8'h0F);
    goto(11); chk("s1_dig1", {4'h0, tif.dig_sel}, 8'h0D); chk("s1_seg1", tif.seg, 8'hAF);
    goto(19); chk("s1_seg2", tif.seg, 8'h90);
    goto(27); chk("s1_dig3", {4'h0, tif.dig_sel}, 8'h07); chk("s1_seg3", tif.seg, 8'hC2);

    // Yellow blink, half-period 64 clk
    restart(3'b010, 4'd3, 3'b001, 4'd7);
    goto(64);  chk("s2_y0", {5'h0, tif.sn_led}, 8'h00);
    goto(65);  chk("s2_y1", {5'h0, tif.sn_led}, 8'h02);
    goto(128); chk("s2_y1b", {5'h0, tif.sn_led}, 8'h02);
    goto(129); chk("s2_y2", {5'h0, tif.sn_led}, 8'h00);

    // All-red: dashes and blinking red on both directions
    restart(3'b100, 4'd0, 3'b100, 4'd0);
    goto(3);  chk("s3_dash_ew", tif.seg, 8'hBF);
    goto(19); chk("s3_dash_sn", tif.seg, 8'hBF);
    goto(64); chk("s3_red0", {5'h0, tif.sn_led}, 8'h00);
    goto(65); chk("s3_sn_red", {5'h0, tif.sn_led}, 8'h04); chk("s3_ew_red", {5'h0, tif.ew_led}, 8'h04);

    // Invalid EW code and out-of-range count
    restart(3'b001, 4'd5, 3'b011, 4'd12);
    goto(3);  chk("s4_ew_cnt_E", tif.seg, 8'h86);
              chk("s4_ew_led", {5'h0, tif.ew_led}, 8'h00);
              chk("s4_sn_led", {5'h0, tif.sn_led}, 8'h01);
    goto(11); chk("s4_ew_lt_E", tif.seg, 8'h86);

    // Async reset mid-slot with blink high
    restart(3'b010, 4'd3, 3'b100, 4'd6);
    goto(84); chk("s5_pre_dig", {4'h0, tif.dig_sel}, 8'h0B);
              chk("s5_pre_led", {5'h0, tif.sn_led}, 8'h02);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("s5_async_seg", tif.seg, 8'hFF);
    chk("s5_async_dig", {4'h0, tif.dig_sel}, 8'h0F);
    chk("s5_async_sn", {5'h0, tif.sn_led}, 8'h00);
    chk("s5_async_ew", {5'h0, tif.ew_led}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto(3); chk("s5_restart_dig", {4'h0, tif.dig_sel}, 8'h0E);
             chk("s5_blink0", {5'h0, tif.sn_led}, 8'h00);

    // Mid-slot count change
    restart(3'b001, 4'd5, 3'b001, 4'd2);
    goto(19);
    @(negedge clk);
    tif.south_north_count = 4'd4;
    goto(20); chk("s6_old", tif.seg, 8'h92);
    goto(21); chk("s6_new", tif.seg, 8'h99); chk("s6_dig", {4'h0, tif.dig_sel}, 8'h0B);

    // Randomized run with occasional input changes and async resets
    restart(rnd_light(), 4'($urandom_range(0, 9)), rnd_light(), 4'($urandom_range(0, 9)));
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) begin
        tif.south_north_light = rnd_light();
        tif.east_west_light   = rnd_light();
      end
      if ($urandom_range(0, 7) == 0) begin
        tif.south_north_count = 4'($urandom_range(0, 15));
        tif.east_west_count   = 4'($urandom_range(0, 15));
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/traffic_display.md
# traffic_display

Display and lamp driver that sits directly downstream of the traffic-light controller. It consumes the two 3-bit light codes and two 4-bit countdown values and time-multiplexes them onto a 4-digit common-anode 7-segment display. It also drives the six lamp LEDs, with yellow and all-red blinking. The block is purely an output stage and never feeds anything back to the controller.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot (≥2)
- BLANK_CYC, 16: anti-ghost blanking cycles at start of each slot (< SCAN_DIV)
- BLINK_FRAMES, 125: complete 4-digit frames per blink half-period (≥1)
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- south_north_light  in  3  001 green, 010 yellow, 100 red
- east_west_light  in  3  same encoding
- south_north_count  in  4  SN remaining time, 0–9 valid
- east_west_count  in  4  EW remaining time, 0–9 valid
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low; dp always 1
- dig_sel  out  4  digit enables, active-low; at most one bit low
- sn_led  out  3  SN lamps {red,yellow,green}, active-high
- ew_led  out  3  EW lamps, same

## Operation
- Input stage: all 14 input bits are registered every clk (sample regs, reset 0). All further logic uses the samples.
- Prescaler `cnt` runs 0..SCAN_DIV-1 and wraps. On wrap, the digit index `idx` advances 0→1→2→3→0.
- Frame counter increments when `idx` wraps 3→0 together with a prescaler wrap. On reaching BLINK_FRAMES, it clears and `blink` toggles.
- Digit map:
  - idx0: EW count
  - idx1: EW light glyph
  - idx2: SN count
  - idx3: SN light glyph
- Active-high glyph patterns, inverted onto seg:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - G=3D, y=6E, r=50, E=79, dash=40
- Light glyph: 001→G, 010→y, 100→r; any other code→E.
- Count glyph:
  - If both samples equal 100 (all-red), both count digits show dash.
  - Otherwise, a count >9 shows E.
- Blanking: while cnt < BLANK_CYC, dig_sel=1111 and seg=FF. Otherwise dig_sel has bit idx low and seg holds the glyph for idx.
- Lamps:
  - Green and red codes drive their lamp bit steady.
  - Yellow drives the yellow bit = blink.
  - All-red (both 100) drives both red bits = blink, and all other lamp bits 0.
  - An invalid code on a direction gives that direction's lamps = 000.
- Reset (async, any time, including mid-slot or mid-blink):
  - Outputs: seg=FF, dig_sel=1111, sn_led=000, ew_led=000.
  - Internal state: cnt=0, idx=0, frame counter=0, blink=0.
- After release, operation restarts at slot 0 with full blanking.

## Timing
- seg, dig_sel, sn_led and ew_led are registered. They are a function of the previous cycle's cnt, idx, blink and samples.
- Input change at edge k appears on lamps at edge k+2. It appears on seg at edge k+2 if the relevant digit is active and unblanked.
- Slot period: exactly SCAN_DIV clk. Frame period: 4·SCAN_DIV clk. Blink half-period: 4·SCAN_DIV·BLINK_FRAMES clk.
- First rising edge after rst_n release: cnt=1, outputs still blanked.
- dig_sel first goes low (bit0) at edge BLANK_CYC+1 after release.
- Within each slot, dig_sel is low for SCAN_DIV−BLANK_CYC consecutive cycles.
- Simultaneous events:
  - Prescaler wrap with idx 3→0 and frame-count terminal in the same cycle: idx=0, frame counter=0 and blink toggles on the same edge.
  - The first frame after reset counts as a full frame.
- Input changes mid-slot take effect immediately (per latency above); no slot restart.

## Test plan
Bench parameters: SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
- Reset hold then release with inputs SN=001/9, EW=100/4 → dig_sel=1111 for 2 cycles, then 1110 with seg=~66 ("4") for 6 cycles. Next slot: 1101 with seg=~50 ("r"). idx3 shows ~3D ("G"), idx2 shows ~6F ("9").
- SN=010 held steady → sn_led yellow bit toggles every 64 clk, starting at 0. Red and green bits stay 0.
- Both lights 100, counts 0 → both count digits seg=~40 (dash). sn_led and ew_led = {blink,0,0}, toggling every 64 clk.
- EW light=011 and EW count=12 → idx1 and idx0 show ~79 ("E"), ew_led=000. SN lamps are unaffected.
- Assert rst_n low mid-slot (idx=2, blink=1) → all outputs return to reset values asynchronously before the next edge. After release, the scan restarts at idx0 with blink=0.
- Change SN count 5→4 at edge k while idx2 is unblanked → seg switches from ~6D to ~66 at edge k+2, with no glitch on dig_sel.
